// File: rtl/mem_bus_pkg.sv
// Shared types and lane helpers for the mem_bus_master Avalon-MM master.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp,
    StDone
  } state_e;

  typedef enum logic {
    ClientFetch,
    ClientData
  } client_e;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;
  localparam logic [1:0] SizeRsvd = 2'b11;

  // Big-endian lanes: offset 0 sits in [31:24], so a byte moves by 8*(3-off),
  // a half by 16 when it sits at offset 0 and not at all at offset 2.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SizeByte: return {~off, 3'b000};
      SizeHalf: return {~off[1], 4'b0000};
      default:  return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      SizeByte: return 32'h0000_00ff;
      SizeHalf: return 32'h0000_ffff;
      default:  return 32'hffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: byte enables, misalignment detect, store data
// steering and load data right-alignment with zero fill.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [1:0]  req_size_i,
  input  logic [1:0]  req_off_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic        misalign_o,
  output logic [31:0] wlanes_o,
  input  logic [1:0]  rsp_size_i,
  input  logic [1:0]  rsp_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  // Byte enables and misalignment for the access about to be issued.
  always_comb begin
    be_o       = 4'b1111;
    misalign_o = 1'b0;
    unique case (req_size_i)
      SizeByte: be_o = 4'b0001 << req_off_i;
      SizeHalf: begin
        be_o       = req_off_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = req_off_i[0];
      end
      SizeWord, SizeRsvd: misalign_o = |req_off_i;
    endcase
  end

  // Upper store bits beyond the access size are dropped before steering.
  always_comb begin
    wlanes_o = (wdata_i & size_mask(req_size_i)) << lane_shift(req_size_i, req_off_i);
    rdata_o  = (rdata_i >> lane_shift(rsp_size_i, rsp_off_i)) & size_mask(rsp_size_i);
  end

endmodule

// File: rtl/mem_bus_master.sv
// Avalon-MM master arbitrating instruction fetch and data clients onto one port.
// Optional bus timeout enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  state_e      state_q, state_d;
  client_e     owner_q, owner_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        read_q, read_d, write_q, write_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;
  logic [3:0]  req_be;
  logic        req_misalign;
  logic [31:0] req_wlanes, rsp_rdata;
  logic        timeout_hit;
  logic        unused_if_addr;

  // Fetches are always whole words.
  assign unused_if_addr = ^if_addr[1:0];

  mem_lane_align u_align (
    .req_size_i (d_size),
    .req_off_i  (d_addr[1:0]),
    .wdata_i    (d_wdata),
    .be_o       (req_be),
    .misalign_o (req_misalign),
    .wlanes_o   (req_wlanes),
    .rsp_size_i (size_q),
    .rsp_off_i  (off_q),
    .rdata_i    (avm_readdata),
    .rdata_o    (rsp_rdata)
  );

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count consecutive stalled BUS cycles; anything else clears the count.
  always_comb begin
    cnt_d = '0;
    if (state_q == StBus && avm_waitrequest) cnt_d = cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q == StBus) && avm_waitrequest &&
                       (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next state: data wins arbitration; misaligned data skips the bus.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (d_req)       state_d = req_misalign ? StDone : StBus;
        else if (if_req) state_d = StBus;
      end
      StBus: begin
        if (timeout_hit)           state_d = StDone;
        else if (!avm_waitrequest) state_d = we_q ? StDone : StResp;
      end
      StResp:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the bus and client registers.
  always_comb begin
    owner_d    = owner_q;
    we_d       = we_q;
    size_d     = size_q;
    off_d      = off_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    d_err_d    = d_err_q;
    unique case (state_q)
      StIdle: begin
        if (d_req) begin
          owner_d = ClientData;
          we_d    = d_we;
          size_d  = d_size;
          off_d   = d_addr[1:0];
          addr_d  = {d_addr[31:2], 2'b00};
          be_d    = req_be;
          wdata_d = req_wlanes;
          d_err_d = req_misalign;
          if (req_misalign) d_rdata_d = '0;
        end else if (if_req) begin
          owner_d = ClientFetch;
          we_d    = 1'b0;
          size_d  = SizeWord;
          off_d   = 2'b00;
          addr_d  = {if_addr[31:2], 2'b00};
          be_d    = 4'b1111;
          wdata_d = '0;
        end
      end
      StBus: begin
        if (timeout_hit) begin
          if (owner_q == ClientData) begin
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_rdata_d = '0;
          end
        end
      end
      StResp: begin
        if (owner_q == ClientData) d_rdata_d  = rsp_rdata;
        else                       if_rdata_d = avm_readdata;
      end
      default: ;
    endcase
    // Strobes are high exactly while the FSM sits in BUS.
    read_d  = (state_d == StBus) && !we_d;
    write_d = (state_d == StBus) && we_d;
  end

  // Bus and client registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= ClientFetch;
      we_q       <= 1'b0;
      size_q     <= SizeWord;
      off_q      <= 2'b00;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      d_err_q    <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      we_q       <= we_d;
      size_q     <= size_d;
      off_q      <= off_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      read_q     <= read_d;
      write_q    <= write_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      d_err_q    <= d_err_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_byteenable = be_q;
  assign avm_writedata  = wdata_q;
  assign if_rdata       = if_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign d_err          = d_err_q;
  assign if_ack         = (state_q == StDone) && (owner_q == ClientFetch);
  assign d_ack          = (state_q == StDone) && (owner_q == ClientData);

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a wait-state programmable bus responder.
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int wait_n = 0;
  int seen = 0;
  int overlap = 0;
  bit stuck = 1'b0;

  mem_bus_master #(
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_req          (if_req),
    .if_addr         (if_addr),
    .if_rdata        (if_rdata),
    .if_ack          (if_ack),
    .d_req           (d_req),
    .d_we            (d_we),
    .d_size          (d_size),
    .d_addr          (d_addr),
    .d_wdata         (d_wdata),
    .d_rdata         (d_rdata),
    .d_ack           (d_ack),
    .d_err           (d_err),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_byteenable  (avm_byteenable),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  always #5 clk = ~clk;

  // Responder: stall the first wait_n strobe cycles of each transfer.
  always @(negedge clk) begin
    if (avm_read && avm_write) overlap++;
    if (avm_read || avm_write) begin
      avm_waitrequest = stuck || (seen < wait_n);
      seen++;
    end else begin
      avm_waitrequest = stuck;
      seen = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic data_xfer(input string tag, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                           input logic [3:0] be_exp, input logic [31:0] wl_exp,
                           input logic [31:0] rd_exp, input logic err_exp, input int ack_exp);
    int cyc;
    int strobes;
    bit got_ack;
    cyc = 0;
    strobes = 0;
    got_ack = 1'b0;
    wait_n = waits;
    d_req = 1'b1;
    d_we = we;
    d_size = size;
    d_addr = addr;
    d_wdata = wdata;
    while (!got_ack && cyc < 200) begin
      step();
      cyc++;
      if (avm_read || avm_write) begin
        strobes++;
        check_val($sformatf("%s.kind", tag), {31'd0, avm_write}, {31'd0, we});
        check_val($sformatf("%s.addr", tag), avm_address, {addr[31:2], 2'b00});
        check_val($sformatf("%s.be", tag), {28'd0, avm_byteenable}, {28'd0, be_exp});
        if (we) check_val($sformatf("%s.wdata", tag), avm_writedata, wl_exp);
      end
      if (d_ack) got_ack = 1'b1;
    end
    check_val($sformatf("%s.ack_cycle", tag), cyc, ack_exp);
    check_val($sformatf("%s.strobes", tag), strobes, err_exp ? 0 : waits + 1);
    check_val($sformatf("%s.err", tag), {31'd0, d_err}, {31'd0, err_exp});
    if (!we || err_exp) check_val($sformatf("%s.rdata", tag), d_rdata, rd_exp);
    d_req = 1'b0;
    step();
    check_val($sformatf("%s.ack_once", tag), {31'd0, d_ack}, 32'd0);
  endtask

  task automatic fetch_xfer(input string tag, input logic [31:0] addr, input int waits,
                            input logic [31:0] rd_exp, input int ack_exp);
    int cyc;
    int strobes;
    bit got_ack;
    cyc = 0;
    strobes = 0;
    got_ack = 1'b0;
    wait_n = waits;
    if_req = 1'b1;
    if_addr = addr;
    while (!got_ack && cyc < 200) begin
      step();
      cyc++;
      if (avm_read || avm_write) begin
        strobes++;
        check_val($sformatf("%s.read", tag), {31'd0, avm_read}, 32'd1);
        check_val($sformatf("%s.addr", tag), avm_address, {addr[31:2], 2'b00});
        check_val($sformatf("%s.be", tag), {28'd0, avm_byteenable}, 32'hf);
      end
      if (if_ack) got_ack = 1'b1;
    end
    check_val($sformatf("%s.ack_cycle", tag), cyc, ack_exp);
    check_val($sformatf("%s.strobes", tag), strobes, waits + 1);
    check_val($sformatf("%s.rdata", tag), if_rdata, rd_exp);
    if_req = 1'b0;
    step();
    check_val($sformatf("%s.ack_once", tag), {31'd0, if_ack}, 32'd0);
  endtask

  initial begin
    int dack_cyc;
    int iack_cyc;
    int fstrobe_cyc;
    int acks;
    rst_n = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_size = 2'b00;
    d_addr = '0;
    d_wdata = '0;
    avm_readdata = '0;
    repeat (3) step();
    check_val("rst.outs", {avm_read, avm_write, if_ack, d_ack, d_err, avm_byteenable}, 32'd0);
    check_val("rst.addr", avm_address | avm_writedata | d_rdata | if_rdata, 32'd0);
    rst_n = 1'b1;
    step();

    avm_readdata = 32'h3c08_abcd;
    fetch_xfer("fetch0", 32'hbfc0_0000, 0, 32'h3c08_abcd, 3);
    data_xfer("sb_off3_w3", 1'b1, 2'b00, 32'hbfc0_0013, 32'h0000_00a5, 3,
              4'b1000, 32'h0000_00a5, 32'h0, 1'b0, 5);
    avm_readdata = 32'h1234_abcd;
    data_xfer("lh_off0", 1'b0, 2'b01, 32'hbfc0_0020, 32'h0, 0,
              4'b0011, 32'h0, 32'h0000_1234, 1'b0, 3);
    data_xfer("lh_off2_w1", 1'b0, 2'b01, 32'hbfc0_0022, 32'h0, 1,
              4'b1100, 32'h0, 32'h0000_abcd, 1'b0, 4);
    data_xfer("lb_off2", 1'b0, 2'b00, 32'hbfc0_0022, 32'h0, 0,
              4'b0100, 32'h0, 32'h0000_00ab, 1'b0, 3);
    data_xfer("sh_off0", 1'b1, 2'b01, 32'hbfc0_0030, 32'h1234_beef, 0,
              4'b0011, 32'hbeef_0000, 32'h0, 1'b0, 2);
    data_xfer("sb_off1", 1'b1, 2'b00, 32'hbfc0_0031, 32'hffff_ff5a, 0,
              4'b0010, 32'h005a_0000, 32'h0, 1'b0, 2);
    avm_readdata = 32'hcafe_f00d;
    data_xfer("lw_rsvd_w2", 1'b0, 2'b11, 32'hbfc0_0040, 32'h0, 2,
              4'b1111, 32'h0, 32'hcafe_f00d, 1'b0, 5);
    data_xfer("sw", 1'b1, 2'b10, 32'hbfc0_0044, 32'hdead_beef, 0,
              4'b1111, 32'hdead_beef, 32'h0, 1'b0, 2);
    data_xfer("lw_misal", 1'b0, 2'b10, 32'hbfc0_0002, 32'h0, 0,
              4'b0000, 32'h0, 32'h0, 1'b1, 1);
    data_xfer("sh_misal", 1'b1, 2'b01, 32'hbfc0_0001, 32'h0000_1111, 0,
              4'b0000, 32'h0, 32'h0, 1'b1, 1);

    // Both clients in the same IDLE cycle: data first, fetch right after.
    avm_readdata = 32'h1122_3344;
    wait_n = 0;
    dack_cyc = 0;
    iack_cyc = 0;
    fstrobe_cyc = 0;
    d_req = 1'b1;
    d_we = 1'b0;
    d_size = 2'b10;
    d_addr = 32'hbfc0_0050;
    if_req = 1'b1;
    if_addr = 32'hbfc0_0060;
    for (int c = 1; c <= 30 && iack_cyc == 0; c++) begin
      step();
      if (avm_read && avm_address == 32'hbfc0_0060 && fstrobe_cyc == 0) fstrobe_cyc = c;
      if (d_ack) begin
        dack_cyc = c;
        d_req = 1'b0;
      end
      if (if_ack) begin
        iack_cyc = c;
        if_req = 1'b0;
      end
    end
    check_val("both.d_ack_cycle", dack_cyc, 3);
    check_val("both.fetch_strobe_cycle", fstrobe_cyc, 5);
    check_val("both.if_ack_cycle", iack_cyc, 7);
    check_val("both.d_rdata", d_rdata, 32'h1122_3344);
    check_val("both.if_rdata", if_rdata, 32'h1122_3344);
    step();

    // Reset asserted while stalled in BUS.
    wait_n = 10;
    d_req = 1'b1;
    d_we = 1'b0;
    d_size = 2'b10;
    d_addr = 32'hbfc0_0070;
    step();
    step();
    check_val("rstbus.pre_read", {31'd0, avm_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rstbus.read_drop", {30'd0, avm_read, avm_write}, 32'd0);
    d_req = 1'b0;
    acks = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      acks += int'(d_ack) + int'(if_ack);
    end
    check_val("rstbus.no_ack", acks, 0);
    rst_n = 1'b1;
    step();
    check_val("rstbus.idle", {30'd0, avm_read, d_ack}, 32'd0);
    wait_n = 0;
    avm_readdata = 32'h0bad_cafe;
    fetch_xfer("fetch_after_rst", 32'hbfc0_0080, 0, 32'h0bad_cafe, 3);

`ifdef MEM_BUS_TIMEOUT_EN
    stuck = 1'b1;
    dack_cyc = 0;
    d_req = 1'b1;
    d_we = 1'b0;
    d_size = 2'b10;
    d_addr = 32'hbfc0_0090;
    for (int c = 1; c <= 200 && dack_cyc == 0; c++) begin
      step();
      if (d_ack) dack_cyc = c;
    end
    check_val("tmo.ack_cycle", dack_cyc, 65);
    check_val("tmo.err", {31'd0, d_err}, 32'd1);
    check_val("tmo.rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    stuck = 1'b0;
    step();
`endif

    check_val("no_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Single Avalon-MM master sitting between the CPU core and the instruction/data memory. It arbitrates an instruction-fetch client and a data client onto one bus port and sequences each transfer through the waitrequest handshake. For sub-word accesses it generates byte enables and steers byte lanes. Read data is returned right-aligned.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: waitrequest cycles before abort; used only with the timeout feature.

Ports (all synchronous to `clk`):
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `if_req` in 1: fetch request; held until `if_ack`.
- `if_addr` in 32: fetch byte address.
- `if_rdata` out 32: fetched word.
- `if_ack` out 1: fetch complete.
- `d_req` in 1: data request; held until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is reserved and treated as word.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data, right-aligned.
- `d_rdata` out 32: load data, right-aligned, upper bits zero.
- `d_ack` out 1: data complete.
- `d_err` out 1: misaligned access; valid with `d_ack`.
- `avm_address` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `avm_read` out 1: bus read strobe.
- `avm_write` out 1: bus write strobe.
- `avm_byteenable` out 4: lane enables.
- `avm_writedata` out 32: lane-steered store data.
- `avm_readdata` in 32: bus read data.
- `avm_waitrequest` in 1: bus stall.

## Operation
- **Lane convention (big-endian):**
  - Byte offset 0 is lane `[31:24]` and is enabled by `byteenable[0]`.
  - Offset 3 is lane `[7:0]`, enabled by `byteenable[3]`.
- **Byte enables:**
  - Byte: one-hot at the offset.
  - Half: offset 0 gives 0011; offset 2 gives 1100.
  - Word: 1111.
- **Fetch:** always a word read with byteenable 1111.
- **Misalignment:** a half-word at an odd address or a word with `addr[1:0]` ≠ 0 performs no bus cycle. The block goes to DONE with `d_err` = 1 and `d_rdata` = 0.
- **States:**
  - IDLE: arbitrate. Data has fixed priority over fetch. Go to BUS, or to DONE on misalignment.
  - BUS: drive the strobe; stay while `avm_waitrequest` = 1. On an edge with waitrequest = 0, a read goes to RESP and a write goes to DONE.
  - RESP: `avm_readdata` is valid this cycle. Capture it, shifted right by lane, into the client register, then go to DONE.
  - DONE: assert the owning client's ack for exactly one cycle, then go to IDLE. Requests are ignored in DONE.
- All `avm_*` outputs are registered. Address, byteenable and writedata are stable for the whole of BUS.
- `avm_read` and `avm_write` are never high together, and are 0 outside BUS.

## Timing
- **Reset values:** all outputs 0 and state IDLE. `rst_n` low mid-transfer drops the strobes immediately (asynchronously) and aborts without ack.
- **Zero-wait read:** `req` sampled at edge 0; strobe high in cycle 1; accepted at edge 1; RESP in cycle 2; ack in cycle 3.
- Each waitrequest cycle adds one cycle of latency.
- **Zero-wait write:** ack in cycle 2.
- A misaligned access acks in cycle 1.
- Back-to-back throughput: the next request is accepted in the IDLE cycle after DONE.
- If both clients request in the same IDLE cycle, data is served first and fetch is served on the next IDLE.

## Configuration
- **`MEM_BUS_TIMEOUT_EN` defined:** a counter runs in BUS.
  - After `TIMEOUT_CYCLES` consecutive waitrequest-high cycles, the strobes drop and the block goes to DONE.
  - Data: `d_err` = 1 and `d_rdata` = 0.
  - Fetch: `if_rdata` = 0 and `if_ack` pulses.
- **Undefined:** BUS waits indefinitely. The counter and the `TIMEOUT_CYCLES` logic are absent.

## Structure
- **Package `mem_bus_pkg`:**
  - State enum (IDLE, BUS, RESP, DONE).
  - `d_size` encodings.
  - Client-select enum (FETCH, DATA).
- **Sub-module `mem_lane_align` (combinational):**
  - Generates byteenable and misalignment.
  - Steers write data into lanes.
  - Shifts read data right and zero-fills.
- The top level holds the FSM, arbitration and registers.

## Test plan
- **Fetch with zero wait:** `if_addr` = BFC00000; mem word 3C08ABCD -> `avm_read` 1 cycle, `if_ack` in cycle 3, `if_rdata` = 3C08ABCD.
- **Store byte with 3 wait cycles:** `d_addr` = BFC00013, `d_wdata` = 000000A5 -> byteenable 1000, writedata 000000A5, strobe held 4 cycles, `d_ack` 1 cycle later.
- **Load half at offset 0:** word 1234ABCD -> byteenable 0011, `d_rdata` = 00001234.
- **Misaligned word:** `d_addr` = BFC00002 -> no strobe, `d_err` and `d_ack` = 1 in cycle 1.
- **Simultaneous requests:** both clients request -> data completes first, fetch follows, no overlapping strobes.
- **Reset and timeout:** `rst_n` low during BUS -> strobes 0 immediately, no ack. With `MEM_BUS_TIMEOUT_EN` and waitrequest stuck at 1 -> `d_err` after 64 cycles.
